// File: rtl/enm_hit_ctrl_if.sv
// Shot request / hit response bundle between the player-shot source and the enemy damage stage.
// Enemy positions come back in from the movement block; HP values go out to it.
interface enm_hit_ctrl_if;
    logic       start;
    logic       shot_vld;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic [9:0] enmx1, enmx2, enmx3, enmx4;
    logic [9:0] enmy1, enmy2, enmy3, enmy4;
    logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
    logic       busy;
    logic       shot_ack;
    logic       hit;
    logic [1:0] hit_id;
    logic       kill;
    logic       all_dead;

    modport master (
        output start, shot_vld, shot_x, shot_y,
        output enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4,
        input  enmhp1, enmhp2, enmhp3, enmhp4,
        input  busy, shot_ack, hit, hit_id, kill, all_dead
    );

    modport slave (
        input  start, shot_vld, shot_x, shot_y,
        input  enmx1, enmx2, enmx3, enmx4, enmy1, enmy2, enmy3, enmy4,
        output enmhp1, enmhp2, enmhp3, enmhp4,
        output busy, shot_ack, hit, hit_id, kill, all_dead
    );
endinterface

// File: rtl/enm_hit_ctrl.sv
// Enemy damage stage: scans four enemies per shot, first box hit takes damage; ack 2+k cycles (miss 5).
// No backpressure: shots arriving while busy are dropped without ack; start aborts an in-flight shot.
module enm_hit_ctrl #(
    parameter logic [6:0] HP_INIT = 7'd100,
    parameter logic [6:0] DMG     = 7'd10,
    parameter int         HIT_W   = 16,
    parameter int         HIT_H   = 16,
    parameter logic [3:0] IFRAME  = 4'd8
) (
    input  logic           clk22,
    input  logic           rst_n,
    enm_hit_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [9:0]  sx_q, sx_d;
    logic [9:0]  sy_q, sy_d;
    logic        hit_q, hit_d;
    logic [1:0]  hit_id_q, hit_id_d;
    logic [6:0]  hp_q [4];
    logic [6:0]  hp_d [4];
    logic [3:0]  cd_q [4];
    logic [3:0]  cd_d [4];
    logic        all_dead_q, all_dead_d;

    logic [9:0]  ex [4];
    logic [9:0]  ey [4];
    logic [10:0] dx, dy, adx, ady;
    logic        scan_hit;
    logic [6:0]  hp_sel;
    logic        resp_hit;

    assign ex[0] = bus.enmx1;
    assign ex[1] = bus.enmx2;
    assign ex[2] = bus.enmx3;
    assign ex[3] = bus.enmx4;
    assign ey[0] = bus.enmy1;
    assign ey[1] = bus.enmy2;
    assign ey[2] = bus.enmy3;
    assign ey[3] = bus.enmy4;

    // Positions are read live from the movement block, only the shot is latched.
    always_comb begin
        dx       = {1'b0, sx_q} - {1'b0, ex[idx_q]};
        dy       = {1'b0, sy_q} - {1'b0, ey[idx_q]};
        adx      = dx[10] ? (~dx + 11'd1) : dx;
        ady      = dy[10] ? (~dy + 11'd1) : dy;
        scan_hit = (hp_q[idx_q] != 7'd0) && (cd_q[idx_q] == 4'd0) &&
                   (adx < 11'(HIT_W)) && (ady < 11'(HIT_H));
    end

    assign hp_sel   = hp_q[hit_id_q];
    assign resp_hit = (state_q == RESP) && hit_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        hit_d    = hit_q;
        hit_id_d = hit_id_q;
        case (state_q)
            IDLE: begin
                if (bus.shot_vld) begin
                    sx_d    = bus.shot_x;
                    sy_d    = bus.shot_y;
                    idx_d   = 2'd0;
                    hit_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    hit_d    = 1'b1;
                    hit_id_d = idx_q;
                    state_d  = RESP;
                end else if (idx_q == 2'd3) begin
                    hit_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.start) begin
            state_d = IDLE;
        end
    end

    // Cooldowns run free of the FSM; damage lands at the end of the RESP cycle.
    always_comb begin
        all_dead_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hp_d[i] = hp_q[i];
            cd_d[i] = (cd_q[i] != 4'd0) ? cd_q[i] - 4'd1 : 4'd0;
            if (resp_hit && (hit_id_q == 2'(i))) begin
                hp_d[i] = (hp_q[i] <= DMG) ? 7'd0 : hp_q[i] - DMG;
                cd_d[i] = IFRAME;
            end
            if (bus.start) begin
                hp_d[i] = HP_INIT;
                cd_d[i] = 4'd0;
            end
            if (hp_d[i] != 7'd0) begin
                all_dead_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            sx_q       <= 10'd0;
            sy_q       <= 10'd0;
            hit_q      <= 1'b0;
            hit_id_q   <= 2'd0;
            all_dead_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hp_q[i] <= HP_INIT;
                cd_q[i] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            hit_q      <= hit_d;
            hit_id_q   <= hit_id_d;
            all_dead_q <= all_dead_d;
            for (int i = 0; i < 4; i++) begin
                hp_q[i] <= hp_d[i];
                cd_q[i] <= cd_d[i];
            end
        end
    end

    // A start in the RESP cycle discards the result, so the ack is withheld too.
    assign bus.busy     = (state_q != IDLE);
    assign bus.shot_ack = (state_q == RESP) && !bus.start;
    assign bus.hit      = resp_hit && !bus.start;
    assign bus.hit_id   = hit_id_q;
    assign bus.kill     = resp_hit && !bus.start && (hp_sel <= DMG);
    assign bus.all_dead = all_dead_q;
    assign bus.enmhp1   = hp_q[0];
    assign bus.enmhp2   = hp_q[1];
    assign bus.enmhp3   = hp_q[2];
    assign bus.enmhp4   = hp_q[3];

endmodule

// File: tb/tb_enm_hit_ctrl.sv
// Scoreboard bench for enm_hit_ctrl: expected acks are queued per shot and matched on shot_ack.
module tb_enm_hit_ctrl;

    localparam int DMG    = 10;
    localparam int IFRAME = 8;

    typedef struct {
        logic       hit;
        logic [1:0] id;
        logic       kill;
        int         ack_cyc;
    } exp_t;

    logic clk22 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk22 = ~clk22;

    enm_hit_ctrl_if bus();

    enm_hit_ctrl dut (
        .clk22 (clk22),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [9:0] px [4];
    logic [9:0] py [4];
    assign bus.enmx1 = px[0];
    assign bus.enmx2 = px[1];
    assign bus.enmx3 = px[2];
    assign bus.enmx4 = px[3];
    assign bus.enmy1 = py[0];
    assign bus.enmy2 = py[1];
    assign bus.enmy3 = py[2];
    assign bus.enmy4 = py[3];

    exp_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;
    int   model_hp [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_cnt++;
        if (obs !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    always @(posedge clk22) cyc <= cyc + 1;

    exp_t mon_e;
    always @(posedge clk22) begin
        #1;
        if (rst_n && bus.shot_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_cycle", cyc, mon_e.ack_cyc);
                chk("hit", bus.hit, mon_e.hit);
                if (mon_e.hit) chk("hit_id", bus.hit_id, mon_e.id);
                chk("kill", bus.kill, mon_e.kill);
            end
        end
    end

    task automatic model_reload();
        for (int i = 0; i < 4; i++) model_hp[i] = 100;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk22);
        if (sb.size() != 0) begin
            chk("ack_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic pulse_shot(input int x, input int y, input int cycles);
        @(negedge clk22);
        bus.shot_x   = 10'(x);
        bus.shot_y   = 10'(y);
        bus.shot_vld = 1'b1;
        repeat (cycles) @(negedge clk22);
        bus.shot_vld = 1'b0;
    endtask

    task automatic push_exp(input logic h, input int id, input int ack_cyc);
        exp_t e;
        e.hit     = h;
        e.id      = 2'(id);
        e.kill    = 1'b0;
        e.ack_cyc = ack_cyc;
        if (h) begin
            e.kill       = (model_hp[id] <= DMG);
            model_hp[id] = e.kill ? 0 : model_hp[id] - DMG;
        end
        sb.push_back(e);
    endtask

    task automatic fire(input int x, input int y, input logic h, input int id);
        pulse_shot(x, y, 1);
        push_exp(h, id, cyc + (h ? 1 + id : 4));
        wait_idle();
    endtask

    task automatic check_hp();
        @(negedge clk22);
        chk("enmhp1", bus.enmhp1, model_hp[0]);
        chk("enmhp2", bus.enmhp2, model_hp[1]);
        chk("enmhp3", bus.enmhp3, model_hp[2]);
        chk("enmhp4", bus.enmhp4, model_hp[3]);
    endtask

    task automatic pulse_start();
        @(negedge clk22);
        bus.start = 1'b1;
        @(negedge clk22);
        bus.start = 1'b0;
        model_reload();
    endtask

    task automatic default_pos();
        px[0] = 10'd40;  py[0] = 10'd40;
        px[1] = 10'd300; py[1] = 10'd300;
        px[2] = 10'd600; py[2] = 10'd300;
        px[3] = 10'd900; py[3] = 10'd50;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.shot_vld = 1'b0;
        bus.shot_x   = 10'd0;
        bus.shot_y   = 10'd0;
        default_pos();
        model_reload();

        repeat (3) @(negedge clk22);
        check_hp();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ack", bus.shot_ack, 0);
        chk("rst_all_dead", bus.all_dead, 0);
        chk("rst_hit_id", bus.hit_id, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk22);

        // basic hit on enemy 0, then a re-shot two cycles after the ack lands in cooldown
        fire(50, 30, 1'b1, 0);
        check_hp();
        fire(50, 30, 1'b0, 0);
        check_hp();
        repeat (IFRAME) @(negedge clk22);
        fire(50, 30, 1'b1, 0);
        check_hp();

        fire(500, 400, 1'b0, 0);
        check_hp();

        px[1] = 10'd200; py[1] = 10'd100;
        px[2] = 10'd200; py[2] = 10'd100;
        fire(200, 100, 1'b1, 1);
        check_hp();
        default_pos();

        while (model_hp[0] > 0) begin
            repeat (IFRAME + 2) @(negedge clk22);
            fire(50, 30, 1'b1, 0);
        end
        check_hp();
        repeat (IFRAME + 2) @(negedge clk22);
        fire(40, 40, 1'b0, 0);
        px[0] = 10'd0; py[0] = 10'd0;
        fire(0, 0, 1'b0, 0);
        chk("all_dead_partial", bus.all_dead, 0);

        for (int k = 1; k < 4; k++) begin
            while (model_hp[k] > 0) begin
                repeat (IFRAME + 2) @(negedge clk22);
                fire(int'(px[k]), int'(py[k]), 1'b1, k);
            end
        end
        check_hp();
        chk("all_dead_set", bus.all_dead, 1);

        pulse_start();
        default_pos();
        check_hp();
        chk("all_dead_clear", bus.all_dead, 0);

        // second sample of a held shot_vld arrives while busy and must vanish
        pulse_shot(300, 300, 2);
        push_exp(1'b1, 1, cyc + 1);
        wait_idle();
        repeat (12) @(negedge clk22);
        chk("drop_sb_empty", sb.size(), 0);
        check_hp();

        fire(50, 30, 1'b1, 0);
        check_hp();
        pulse_shot(500, 400, 1);
        @(negedge clk22);
        bus.start = 1'b1;
        @(negedge clk22);
        bus.start = 1'b0;
        model_reload();
        repeat (8) @(negedge clk22);
        check_hp();
        chk("start_busy", bus.busy, 0);

        fire(600, 300, 1'b1, 2);
        check_hp();
        pulse_shot(500, 400, 1);
        @(negedge clk22);
        #2 rst_n = 1'b0;
        #1;
        model_reload();
        chk("arst_busy", bus.busy, 0);
        chk("arst_ack", bus.shot_ack, 0);
        chk("arst_all_dead", bus.all_dead, 0);
        chk("arst_hp1", bus.enmhp1, model_hp[0]);
        chk("arst_hp3", bus.enmhp3, model_hp[2]);
        @(negedge clk22);
        rst_n = 1'b1;
        repeat (8) @(negedge clk22);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
